// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO holding {pc, ir} pairs in a circular buffer.
// Single-cycle flush discards all entries.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_pc,
    input  logic [31:0]              enq_ir,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_ir,
    input  logic                     deq_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_mem_pc [DEPTH];
    logic [31:0]   r_mem_ir [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_enq_fire;
    logic w_deq_fire;

    // Handshakes depend only on registered count and flush, never on the peer's valid/ready.
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign enq_ready  = ~w_full & ~flush;
    assign deq_valid  = ~w_empty & ~flush;
    assign w_enq_fire = enq_valid & enq_ready;
    assign w_deq_fire = deq_valid & deq_ready;

    assign deq_pc = deq_valid ? r_mem_pc[r_head] : 32'h0;
    assign deq_ir = deq_valid ? r_mem_ir[r_head] : 32'h0;
    assign count  = r_count;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_fire) r_tail <= r_tail + AW'(1);
            if (w_deq_fire) r_head <= r_head + AW'(1);
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; output gating hides stale entries.
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_mem_pc[r_tail] <= enq_pc;
            r_mem_ir[r_tail] <= enq_ir;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared every
// cycle, plus directed literal checks for reset, full, drain, flush and wrap.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enq_valid = 1'b0;
    logic [31:0]   enq_pc = '0;
    logic [31:0]   enq_ir = '0;
    logic          enq_ready;
    logic          deq_valid;
    logic [31:0]   deq_pc;
    logic [31:0]   deq_ir;
    logic          deq_ready = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;
    ent_t q[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_ir    (enq_ir),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_ir    (deq_ir),
        .deq_ready (deq_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of entries, updated at each edge from the rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            automatic bit can_enq = (q.size() != DEPTH);
            automatic bit can_deq = (q.size() != 0);
            if (can_deq && deq_ready) void'(q.pop_front());
            if (can_enq && enq_valid) q.push_back('{pc: enq_pc, ir: enq_ir});
        end
    end

    // Compare process: outputs versus model, mid-cycle on every falling edge.
    always @(negedge clk) begin
        automatic bit   exp_rdy = (q.size() != DEPTH) && !flush;
        automatic bit   exp_vld = (q.size() != 0) && !flush;
        automatic ent_t head    = exp_vld ? q[0] : '0;
        check("count",     64'(count),     64'(q.size()));
        check("enq_ready", 64'(enq_ready), 64'(exp_rdy));
        check("deq_valid", 64'(deq_valid), 64'(exp_vld));
        check("deq_pc",    64'(deq_pc),    64'(head.pc));
        check("deq_ir",    64'(deq_ir),    64'(head.ir));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] fill_ir [4];
        fill_ir[0] = 32'h13;
        fill_ir[1] = 32'h93;
        fill_ir[2] = 32'h113;
        fill_ir[3] = 32'h193;

        // Reset asserted asynchronously, outputs must respond before any edge.
        #1 rst = 1'b1;
        #1;
        check("rst_count",     64'(count),     64'd0);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_deq_pc",    64'(deq_pc),    64'd0);
        check("rst_deq_ir",    64'(deq_ir),    64'd0);
        step();
        step();
        rst = 1'b0;
        deq_ready = 1'b1;
        repeat (3) step();
        check("idle_deq_valid", 64'(deq_valid), 64'd0);

        // Fill to full.
        deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h60 + 32'(4 * i);
            enq_ir    = fill_ir[i];
            step();
        end
        check("full_count", 64'(count),     64'd4);
        check("full_ready", 64'(enq_ready), 64'd0);
        enq_pc = 32'h70;
        enq_ir = 32'h213;
        repeat (3) step();
        check("full_hold_count", 64'(count), 64'd4);
        enq_valid = 1'b0;

        // Drain in push order.
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", 64'(deq_pc), 64'(32'h60 + 32'(4 * i)));
            check("drain_ir", 64'(deq_ir), 64'(fill_ir[i]));
            step();
        end
        check("drain_empty", 64'(deq_valid), 64'd0);

        // Continuous push/pop across the pointer wrap.
        for (int i = 0; i < 6; i++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h100 + 32'(4 * i);
            enq_ir    = 32'hA000 + 32'(i);
            step();
            check("wrap_pc", 64'(deq_pc), 64'(32'h100 + 32'(4 * i)));
        end
        enq_valid = 1'b0;
        step();
        check("wrap_empty", 64'(deq_valid), 64'd0);

        // Simultaneous push/pop with two entries buffered.
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        enq_pc = 32'h300; step();
        enq_pc = 32'h304; step();
        enq_pc = 32'h308;
        deq_ready = 1'b1;
        step();
        enq_valid = 1'b0;
        check("both_count", 64'(count),  64'd2);
        check("both_head",  64'(deq_pc), 64'h304);
        step();
        check("both_tail", 64'(deq_pc), 64'h308);
        step();

        // Flush with three buffered, competing push and pop ignored.
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_pc = 32'h400 + 32'(4 * i);
            step();
        end
        check("pre_flush_count", 64'(count), 64'd3);
        flush     = 1'b1;
        enq_pc    = 32'h80;
        deq_ready = 1'b1;
        #1;
        check("flush_deq_valid", 64'(deq_valid), 64'd0);
        check("flush_enq_ready", 64'(enq_ready), 64'd0);
        step();
        flush = 1'b0;
        enq_valid = 1'b0;
        check("post_flush_count", 64'(count), 64'd0);
        enq_valid = 1'b1;
        enq_pc    = 32'h200;
        step();
        enq_valid = 1'b0;
        check("after_flush_valid", 64'(deq_valid), 64'd1);
        check("after_flush_pc",    64'(deq_pc),    64'h200);
        step();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            enq_valid = 1'($urandom_range(0, 3) != 0);
            deq_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            enq_pc    = $urandom;
            enq_ir    = $urandom;
            step();
        end

        // Reset mid-cycle with two entries buffered.
        flush = 1'b1;
        enq_valid = 1'b0;
        step();
        flush = 1'b0;
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        enq_pc = 32'h500; step();
        enq_pc = 32'h504; step();
        enq_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_count", 64'(count),     64'd0);
        check("mid_rst_valid", 64'(deq_valid), 64'd0);
        step();
        rst = 1'b0;
        deq_ready = 1'b1;
        repeat (3) begin
            step();
            check("post_rst_valid", 64'(deq_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
